cpu_run_ctrl: RTL and testbench

Run/step/breakpoint controller that sequences the single-cycle RISC-V core by driving its global_en input. It accepts debug commands over a valid/ready port and watches the fetch address and instruction. It freezes the core on a breakpoint, on completion of a step count, on an explicit stop, or after the HALT instruction (ebreak) commits. It sits between the debug host/UART bridge and the CPU top level.

---
 rtl/cpu_run_ctrl_pkg.sv | 30 +++
 rtl/cpu_run_ctrl.sv | 138 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the run/step/breakpoint controller and the CPU top level:
// command op codes, controller states, stop reasons and the HALT (ebreak) encoding.
package cpu_run_ctrl_pkg;

  localparam logic [31:0] HALT_INST = 32'h00100073;

  typedef enum logic [1:0] {
    OP_RUN   = 2'd0,
    OP_STEP  = 2'd1,
    OP_STOP  = 2'd2,
    OP_SETBP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    RSN_NONE       = 3'd0,
    RSN_STOP_CMD   = 3'd1,
    RSN_STEP_DONE  = 3'd2,
    RSN_BREAKPOINT = 3'd3,
    RSN_HALT       = 3'd4,
    RSN_TIMEOUT    = 3'd5
  } reason_e;

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller gating the single-cycle core through global_en.
// Optional run-cycle watchdog is built when CPU_RUN_CTRL_WDOG_EN is defined.
module cpu_run_ctrl #(
  parameter logic [31:0] HALT_INST   = cpu_run_ctrl_pkg::HALT_INST,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] WDOG_CYCLES = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic [31:0] cpu_pc,
  input  logic [31:0] cpu_inst,
  output logic        global_en,
  output logic        busy,
  output logic        halted,
  output logic [2:0]  stop_reason,
  output logic        cmd_err,
  output logic [31:0] retired
);
  import cpu_run_ctrl_pkg::*;

  state_e           state;
  reason_e          reason;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] step_load;
  logic             bp_en;
  logic [29:0]      bp_addr;
  logic             skip_bp;
  logic             bp_hit;
  logic             halt_hit;
  logic             do_run;
  logic             do_step;
  logic             do_stop;
  logic             set_bp;
  logic             unused_bits;

`ifdef CPU_RUN_CTRL_WDOG_EN
  logic [31:0] run_cycles;
  assign unused_bits = cmd_arg[1] ^ (^cpu_pc[1:0]);
`else
  assign unused_bits = cmd_arg[1] ^ (^cpu_pc[1:0]) ^ (^WDOG_CYCLES);
`endif

  assign cmd_ready = 1'b1;
  assign do_run    = cmd_valid && (cmd_op == OP_RUN);
  assign do_step   = cmd_valid && (cmd_op == OP_STEP);
  assign do_stop   = cmd_valid && (cmd_op == OP_STOP);
  assign set_bp    = cmd_valid && (cmd_op == OP_SETBP);

  // skip_bp lets a RUN issued while parked on a breakpoint execute that instruction
  assign bp_hit    = bp_en && (cpu_pc[31:2] == bp_addr) && !skip_bp;
  assign global_en = ((state == ST_RUN) && !bp_hit) || (state == ST_STEP);
  assign halt_hit  = global_en && (cpu_inst == HALT_INST);

  assign busy        = (state == ST_RUN) || (state == ST_STEP);
  assign halted      = (state == ST_HALTED);
  assign stop_reason = reason;

  // A step count of zero still executes one instruction
  assign step_load = (cmd_arg[CNT_W-1:0] == '0) ? CNT_W'(1) : cmd_arg[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      reason   <= RSN_NONE;
      step_cnt <= '0;
      bp_en    <= 1'b0;
      bp_addr  <= '0;
      skip_bp  <= 1'b0;
      cmd_err  <= 1'b0;
      retired  <= '0;
`ifdef CPU_RUN_CTRL_WDOG_EN
      run_cycles <= '0;
`endif
    end else begin
      cmd_err <= 1'b0;
      if (global_en) begin
        retired <= retired + 32'd1;
        skip_bp <= 1'b0;
      end
      if (set_bp) begin
        bp_en   <= cmd_arg[0];
        bp_addr <= cmd_arg[31:2];
      end
`ifdef CPU_RUN_CTRL_WDOG_EN
      if (state == ST_RUN) run_cycles <= run_cycles + 32'd1;
`endif
      case (state)
        ST_IDLE: begin
          if (do_run) begin
            state   <= ST_RUN;
            skip_bp <= 1'b1;
            reason  <= RSN_NONE;
`ifdef CPU_RUN_CTRL_WDOG_EN
            run_cycles <= '0;
`endif
          end else if (do_step) begin
            state    <= ST_STEP;
            skip_bp  <= 1'b1;
            reason   <= RSN_NONE;
            step_cnt <= step_load;
          end
        end
        ST_RUN, ST_STEP: begin
          if (state == ST_STEP) step_cnt <= step_cnt - CNT_W'(1);
          if (do_run || do_step) cmd_err <= 1'b1;
          // Stop causes in priority order; HALT always wins
          if (halt_hit) begin
            state  <= ST_HALTED;
            reason <= RSN_HALT;
          end else if ((state == ST_RUN) && bp_hit) begin
            state  <= ST_IDLE;
            reason <= RSN_BREAKPOINT;
          end else if (do_stop) begin
            state  <= ST_IDLE;
            reason <= RSN_STOP_CMD;
          end else if ((state == ST_STEP) && (step_cnt == CNT_W'(1))) begin
            state  <= ST_IDLE;
            reason <= RSN_STEP_DONE;
`ifdef CPU_RUN_CTRL_WDOG_EN
          end else if ((state == ST_RUN) && (run_cycles == WDOG_CYCLES - 32'd1)) begin
            state  <= ST_IDLE;
            reason <= RSN_TIMEOUT;
`endif
          end
        end
        ST_HALTED: begin
          if (do_run || do_step) cmd_err <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: a tiny behavioural core plus a reference model
// of the controller rules, directed table, hand sequences and randomized commands.
module tb_cpu_run_ctrl;

`ifdef CPU_RUN_CTRL_WDOG_EN
  localparam logic [31:0] WD = 32'd8;
`else
  localparam logic [31:0] WD = 32'd1000000;
`endif
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALTED = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] cpu_inst;
  logic        global_en, busy, halted, cmd_err;
  logic [2:0]  stop_reason;
  logic [31:0] retired;
  logic [31:0] mem [64];

  always #5 clk = ~clk;
  assign cpu_inst = mem[pc[7:2]];

  cpu_run_ctrl #(.WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cpu_pc(pc), .cpu_inst(cpu_inst),
    .global_en(global_en), .busy(busy), .halted(halted),
    .stop_reason(stop_reason), .cmd_err(cmd_err), .retired(retired)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the controller, kept in plain integers
  int          m_mode, m_reason, m_left, m_run_cyc;
  logic [31:0] m_retired;
  bit          m_bp_en, m_skip, m_err;
  logic [29:0] m_bp_word;

  typedef struct {
    bit          v;
    logic [1:0]  op;
    logic [31:0] arg;
    bit          en;
    bit          bsy;
    bit          hlt;
    logic [2:0]  rsn;
    bit          err;
    logic [31:0] ret;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t pc=%0h)", name, act, exp, $time, pc);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_reason = 0; m_left = 0; m_run_cyc = 0;
    m_retired = 0; m_bp_en = 0; m_skip = 0; m_err = 0; m_bp_word = 0;
  endtask

  function automatic bit model_en();
    bit on_bp;
    on_bp = m_bp_en && (pc[31:2] == m_bp_word) && !m_skip;
    return ((m_mode == M_RUN) && !on_bp) || (m_mode == M_STEP);
  endfunction

  task automatic model_step(input bit v, input logic [1:0] op, input logic [31:0] arg, input bit r);
    bit en, nxt_err, active;
    int old;
    if (r) begin
      model_reset();
      return;
    end
    en = model_en();
    old = m_mode;
    active = (old == M_RUN) || (old == M_STEP);
    nxt_err = 0;
    if (en) begin
      m_retired = m_retired + 1;
      m_skip = 0;
    end
    if (v && op == 2'd3) begin
      m_bp_en = arg[0];
      m_bp_word = arg[31:2];
    end
    if (active) begin
      if (en && mem[pc[7:2]] == EBREAK) begin
        m_mode = M_HALTED; m_reason = 4;
      end else if (old == M_RUN && !en) begin
        m_mode = M_IDLE; m_reason = 3;
      end else if (v && op == 2'd2) begin
        m_mode = M_IDLE; m_reason = 1;
      end else if (old == M_STEP && m_left == 1) begin
        m_mode = M_IDLE; m_reason = 2;
`ifdef CPU_RUN_CTRL_WDOG_EN
      end else if (old == M_RUN && m_run_cyc == int'(WD) - 1) begin
        m_mode = M_IDLE; m_reason = 5;
`endif
      end
      if (old == M_STEP) m_left--;
      if (old == M_RUN) m_run_cyc++;
    end
    if (v && (op == 2'd0 || op == 2'd1)) begin
      if (old == M_IDLE) begin
        m_mode = (op == 2'd0) ? M_RUN : M_STEP;
        m_skip = 1; m_reason = 0; m_run_cyc = 0;
        m_left = (arg[15:0] == 16'd0) ? 1 : int'(arg[15:0]);
      end else begin
        nxt_err = 1;
      end
    end
    m_err = nxt_err;
  endtask

  task automatic apply_stimulus(input bit v, input logic [1:0] op, input logic [31:0] arg, input bit r);
    cmd_valid = v; cmd_op = op; cmd_arg = arg; rst = r;
    #1;
  endtask

  task automatic check_output();
    check("global_en", {31'd0, global_en}, {31'd0, model_en()});
    check("busy", {31'd0, busy}, {31'd0, (m_mode == M_RUN || m_mode == M_STEP)});
    check("halted", {31'd0, halted}, {31'd0, (m_mode == M_HALTED)});
    check("stop_reason", {29'd0, stop_reason}, m_reason);
    check("cmd_err", {31'd0, cmd_err}, {31'd0, m_err});
    check("retired", retired, m_retired);
  endtask

  // Advance past the clock edge; the core model fetches the next word when enabled
  task automatic advance(input bit v, input logic [1:0] op, input logic [31:0] arg, input bit r, output bit en);
    en = global_en;
    model_step(v, op, arg, r);
    @(posedge clk);
    #1;
    if (r) pc = 32'd0;
    else if (en) pc = pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic run_cycle(input bit v, input logic [1:0] op, input logic [31:0] arg, input bit r, output bit en);
    apply_stimulus(v, op, arg, r);
    check_output();
    advance(v, op, arg, r, en);
  endtask

  task automatic run_n(input int n, output int ens, output int errs);
    bit en;
    ens = 0; errs = 0;
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0);
      if (cmd_err) errs++;
      check_output();
      advance(1'b0, 2'd0, 32'd0, 1'b0, en);
      if (en) ens++;
    end
  endtask

  task automatic load_program(input int halt_word);
    for (int i = 0; i < 64; i++) mem[i] = (i == halt_word) ? EBREAK : NOP;
  endtask

  vec_t tbl [12];
  bit   en;
  int   ens, errs, total;

  initial begin
    model_reset();
    load_program(4);
    @(negedge clk);

    // Program ends in ebreak at pc 0x10: five enabled cycles then halted
    run_cycle(1'b0, 2'd0, 32'd0, 1'b1, en);
    run_cycle(1'b1, 2'd0, 32'd0, 1'b0, en);
    run_n(10, ens, errs);
    check("run_to_halt_en_cycles", ens, 5);
    check("run_to_halt_retired", retired, 32'd5);
    check("run_to_halt_reason", {29'd0, stop_reason}, 32'd4);
    check("run_to_halt_halted", {31'd0, halted}, 32'd1);

    // Directed table: breakpoint at 0x8, resume through it, halt, rejected STEP
    tbl[0]  = '{1'b1, 2'd3, 32'h9, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0};
    tbl[1]  = '{1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0};
    tbl[2]  = '{1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0};
    tbl[3]  = '{1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd1};
    tbl[4]  = '{1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'd2};
    tbl[5]  = '{1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 32'd2};
    tbl[6]  = '{1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd2};
    tbl[7]  = '{1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd3};
    tbl[8]  = '{1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd4};
    tbl[9]  = '{1'b1, 2'd1, 32'h3, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 32'd5};
    tbl[10] = '{1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 32'd5};
    tbl[11] = '{1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 32'd5};
    run_cycle(1'b0, 2'd0, 32'd0, 1'b1, en);
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(tbl[i].v, tbl[i].op, tbl[i].arg, 1'b0);
      check_output();
      check($sformatf("tbl%0d_en", i), {31'd0, global_en}, {31'd0, tbl[i].en});
      check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
      check($sformatf("tbl%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].hlt});
      check($sformatf("tbl%0d_reason", i), {29'd0, stop_reason}, {29'd0, tbl[i].rsn});
      check($sformatf("tbl%0d_err", i), {31'd0, cmd_err}, {31'd0, tbl[i].err});
      check($sformatf("tbl%0d_retired", i), retired, tbl[i].ret);
      advance(tbl[i].v, tbl[i].op, tbl[i].arg, 1'b0, en);
    end

    // STEP 3 then STEP 0
    run_cycle(1'b0, 2'd0, 32'd0, 1'b1, en);
    run_cycle(1'b1, 2'd1, 32'd3, 1'b0, en);
    run_n(5, ens, errs);
    check("step3_en_cycles", ens, 3);
    check("step3_reason", {29'd0, stop_reason}, 32'd2);
    check("step3_busy", {31'd0, busy}, 32'd0);
    run_cycle(1'b1, 2'd1, 32'd0, 1'b0, en);
    run_n(3, ens, errs);
    check("step0_en_cycles", ens, 1);
    check("step0_reason", {29'd0, stop_reason}, 32'd2);

    // RUN, rejected RUN while busy, then STOP as the fifth enabled cycle
    load_program(20);
    run_cycle(1'b0, 2'd0, 32'd0, 1'b1, en);
    run_cycle(1'b1, 2'd0, 32'd0, 1'b0, en);
    total = 0;
    run_n(2, ens, errs); total += ens;
    run_cycle(1'b1, 2'd0, 32'd0, 1'b0, en); total += int'(en);
    run_n(1, ens, errs); total += ens;
    check("busy_run_err_pulse", errs, 1);
    run_cycle(1'b1, 2'd2, 32'd0, 1'b0, en); total += int'(en);
    run_n(3, ens, errs); total += ens;
    check("stop_en_cycles", total, 5);
    check("stop_reason", {29'd0, stop_reason}, 32'd1);
    check("stop_err_after", errs, 0);
    run_cycle(1'b1, 2'd2, 32'd0, 1'b0, en);
    run_n(1, ens, errs);
    check("stop_in_idle_reason", {29'd0, stop_reason}, 32'd1);

    // STEP 5 across a breakpoint on the 2nd instruction, ebreak as the 4th
    load_program(3);
    run_cycle(1'b0, 2'd0, 32'd0, 1'b1, en);
    run_cycle(1'b1, 2'd3, 32'h5, 1'b0, en);
    run_cycle(1'b1, 2'd1, 32'd5, 1'b0, en);
    run_n(8, ens, errs);
    check("step_bp_en_cycles", ens, 4);
    check("step_bp_reason", {29'd0, stop_reason}, 32'd4);

    // Reset mid-RUN clears everything including the breakpoint
    load_program(40);
    run_cycle(1'b0, 2'd0, 32'd0, 1'b1, en);
    run_cycle(1'b1, 2'd3, 32'h11, 1'b0, en);
    run_cycle(1'b1, 2'd0, 32'd0, 1'b0, en);
    run_n(2, ens, errs);
    run_cycle(1'b0, 2'd0, 32'd0, 1'b1, en);
    apply_stimulus(1'b0, 2'd0, 32'd0, 1'b0);
    check("rst_mid_run_en", {31'd0, global_en}, 32'd0);
    check("rst_mid_run_retired", retired, 32'd0);
    advance(1'b0, 2'd0, 32'd0, 1'b0, en);
    run_cycle(1'b1, 2'd0, 32'd0, 1'b0, en);
    run_n(7, ens, errs);
    check("rst_clears_bp_en_cycles", ens, 7);
    check("rst_clears_bp_busy", {31'd0, busy}, 32'd1);

`ifdef CPU_RUN_CTRL_WDOG_EN
    // Endless run trips the watchdog after WD enabled cycles
    run_cycle(1'b0, 2'd0, 32'd0, 1'b1, en);
    run_cycle(1'b1, 2'd0, 32'd0, 1'b0, en);
    run_n(12, ens, errs);
    check("wdog_en_cycles", ens, 8);
    check("wdog_reason", {29'd0, stop_reason}, 32'd5);
`endif

    // Randomized commands against the reference model
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 19) == 0) ? EBREAK : $urandom;
    run_cycle(1'b0, 2'd0, 32'd0, 1'b1, en);
    for (int i = 0; i < 2000; i++) begin
      bit          v, r;
      logic [1:0]  op;
      logic [31:0] arg;
      r  = ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 4) == 0);
      op = 2'($urandom_range(0, 3));
      case (op)
        2'd1:    arg = $urandom_range(0, 6);
        2'd3:    arg = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 1));
        default: arg = $urandom;
      endcase
      run_cycle(v, op, arg, r, en);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
